// File: rtl/bs_pkg.sv
// Shared packet-format definitions for the bs_gnrtr bus endpoint:
// field layout, default widths and the receive-side address classification.
package bs_pkg;

  localparam int          PCKG_SZ_DEF   = 32;
  localparam logic [7:0]  BROADCAST_DEF = 8'hFF;
  localparam int          HDR_W         = 32;
  localparam int          CNT_W         = 16;

  typedef enum logic [1:0] {
    RX_ACCEPT   = 2'd0,
    RX_ECHO     = 2'd1,
    RX_MISROUTE = 2'd2
  } rx_class_e;

  // Header is the top HDR_W bits of a packet: target, source, ID.
  function automatic logic [7:0] pkt_target(input logic [HDR_W-1:0] hdr);
    return hdr[31:24];
  endfunction

  function automatic logic [7:0] pkt_source(input logic [HDR_W-1:0] hdr);
    return hdr[23:16];
  endfunction

  function automatic logic [15:0] pkt_id(input logic [HDR_W-1:0] hdr);
    return hdr[15:0];
  endfunction

  // A broadcast we originated ourselves comes back as an echo and is ignored.
  function automatic rx_class_e rx_classify(input logic [HDR_W-1:0] hdr,
                                            input logic [7:0] my_id,
                                            input logic [7:0] bcast);
    rx_class_e cls;
    if (pkt_target(hdr) == my_id) begin
      cls = RX_ACCEPT;
    end else if (pkt_target(hdr) == bcast) begin
      cls = (pkt_source(hdr) == my_id) ? RX_ECHO : RX_ACCEPT;
    end else begin
      cls = RX_MISROUTE;
    end
    return cls;
  endfunction

endpackage

// File: rtl/bs_sync_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty flags.
// A write while full is accepted when a read frees the slot in the same cycle.
module bs_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_accept;
  logic             rd_accept;

  always_comb begin
    wr_accept = wr_en && (!full_q || rd_en);
    rd_accept = rd_en && !empty_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_accept && !rd_accept) begin
      count_d = count_q + CW'(1);
    end else if (rd_accept && !wr_accept) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is deliberately left out of reset; the empty flag masks stale data.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/bs_endpoint.sv
// Per-port bus endpoint: TX FIFO toward the bus pull interface, address-filtered
// RX FIFO toward the host, saturating drop/misroute counters and a sticky error.
module bs_endpoint
  import bs_pkg::*;
#(
  parameter int         PCKG_SZ   = PCKG_SZ_DEF,
  parameter int         DEPTH     = 16,
  parameter logic [7:0] ID        = 8'd0,
  parameter logic [7:0] BROADCAST = BROADCAST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [PCKG_SZ-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng,
  input  logic               pop,
  output logic [PCKG_SZ-1:0] D_pop,
  input  logic               push,
  input  logic [PCKG_SZ-1:0] D_push,
  output logic               rx_pndng,
  output logic [PCKG_SZ-1:0] rx_data,
  input  logic               rx_pop,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic [CNT_W-1:0]   misroute_cnt,
  output logic               err
);

  logic             tx_empty;
  logic             rx_empty;
  logic             rx_full;
  logic [HDR_W-1:0] rx_hdr;
  rx_class_e        rx_class;
  logic             rx_wr;

  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] misroute_cnt_q, misroute_cnt_d;
  logic             err_q, err_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  bs_sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tx_wr),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (D_pop),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  bs_sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_wr),
    .wr_data (D_push),
    .rd_en   (rx_pop),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  always_comb begin
    rx_hdr         = D_push[PCKG_SZ-1 -: HDR_W];
    rx_class       = rx_classify(rx_hdr, ID, BROADCAST);
    rx_wr          = push && (rx_class == RX_ACCEPT);
    drop_cnt_d     = drop_cnt_q;
    misroute_cnt_d = misroute_cnt_q;
    err_d          = err_q;
    // An accepted packet is lost only when the FIFO is full and nobody frees a slot.
    if (rx_wr && rx_full && !rx_pop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
    if (push && (rx_class == RX_MISROUTE)) begin
      misroute_cnt_d = sat_inc(misroute_cnt_q);
    end
    if ((pop && tx_empty) || (rx_pop && rx_empty)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q     <= '0;
      misroute_cnt_q <= '0;
      err_q          <= 1'b0;
    end else begin
      drop_cnt_q     <= drop_cnt_d;
      misroute_cnt_q <= misroute_cnt_d;
      err_q          <= err_d;
    end
  end

  assign pndng        = !tx_empty;
  assign rx_pndng     = !rx_empty;
  assign drop_cnt     = drop_cnt_q;
  assign misroute_cnt = misroute_cnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_bs_endpoint.sv
// Self-checking bench for bs_endpoint: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_bs_endpoint;

  localparam int         DEPTH = 16;
  localparam logic [7:0] MY_ID = 8'd1;
  localparam logic [7:0] BC    = 8'hFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_wr = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_full;
  logic        pndng;
  logic        pop = 1'b0;
  logic [31:0] D_pop;
  logic        push = 1'b0;
  logic [31:0] D_push = '0;
  logic        rx_pndng;
  logic [31:0] rx_data;
  logic        rx_pop = 1'b0;
  logic [15:0] drop_cnt;
  logic [15:0] misroute_cnt;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [31:0] tx_m[$];
  logic [31:0] rx_m[$];
  int          drop_m;
  int          mis_m;
  bit          err_m;

  bs_endpoint #(.PCKG_SZ(32), .DEPTH(DEPTH), .ID(MY_ID), .BROADCAST(BC)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_wr        (tx_wr),
    .tx_data      (tx_data),
    .tx_full      (tx_full),
    .pndng        (pndng),
    .pop          (pop),
    .D_pop        (D_pop),
    .push         (push),
    .D_push       (D_push),
    .rx_pndng     (rx_pndng),
    .rx_data      (rx_data),
    .rx_pop       (rx_pop),
    .drop_cnt     (drop_cnt),
    .misroute_cnt (misroute_cnt),
    .err          (err)
  );

  always #5 clk = ~clk;

  logic [99:0] act_vec;
  assign act_vec = {pndng, tx_full, D_pop, rx_pndng, rx_data, drop_cnt, misroute_cnt, err};

  function automatic logic [99:0] exp_vec();
    logic [31:0] th, rh;
    logic [15:0] d16, m16;
    th  = (tx_m.size() != 0) ? tx_m[0] : 32'h0;
    rh  = (rx_m.size() != 0) ? rx_m[0] : 32'h0;
    d16 = drop_m[15:0];
    m16 = mis_m[15:0];
    return {tx_m.size() != 0, tx_m.size() == DEPTH, th,
            rx_m.size() != 0, rh, d16, m16, err_m};
  endfunction

  function automatic void model_reset();
    tx_m.delete();
    rx_m.delete();
    drop_m = 0;
    mis_m  = 0;
    err_m  = 1'b0;
  endfunction

  function automatic void model_step(input bit wr, input logic [31:0] wd, input bit p,
                                     input bit ps, input logic [31:0] pd, input bit rp);
    int  tsz, rsz;
    bit  acc, mis;
    tsz = tx_m.size();
    rsz = rx_m.size();
    if (p && tsz == 0) err_m = 1'b1;
    if (rp && rsz == 0) err_m = 1'b1;
    if (p && tsz > 0) void'(tx_m.pop_front());
    if (wr && (tsz < DEPTH || p)) tx_m.push_back(wd);
    acc = (pd[31:24] == MY_ID) || (pd[31:24] == BC && pd[23:16] != MY_ID);
    mis = (pd[31:24] != MY_ID) && (pd[31:24] != BC);
    if (rp && rsz > 0) void'(rx_m.pop_front());
    if (ps && acc) begin
      if (rsz < DEPTH || rp) rx_m.push_back(pd);
      else if (drop_m < 65535) drop_m++;
    end
    if (ps && mis && mis_m < 65535) mis_m++;
  endfunction

  task automatic tick(input bit wr, input logic [31:0] wd, input bit p,
                      input bit ps, input logic [31:0] pd, input bit rp);
    tx_wr = wr; tx_data = wd; pop = p; push = ps; D_push = pd; rx_pop = rp;
    @(posedge clk);
    model_step(wr, wd, p, ps, pd, rp);
    #1;
    tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_pop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_pkt();
    logic [7:0] t, s;
    case ($urandom_range(0, 3))
      0, 3:    t = MY_ID;
      1:       t = BC;
      default: t = 8'($urandom_range(2, 254));
    endcase
    s = ($urandom_range(0, 2) == 0) ? MY_ID : 8'($urandom_range(2, 200));
    return {t, s, 16'($urandom)};
  endfunction

  task automatic test_reset();
    tx_wr = 1'b1; tx_data = $urandom; push = 1'b1; D_push = {MY_ID, 24'h123456};
    do_reset();
    tx_wr = 1'b0; push = 1'b0;
    checks++;
    if (act_vec !== 100'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", act_vec, 100'h0);
    end
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_tx_order();
    do_reset();
    tick(1, 32'h01000000, 0, 0, 0, 0);
    checks++;
    if (pndng !== 1'b1 || D_pop !== 32'h01000000) begin
      errors++;
      $display("FAIL tx_first_latency: got pndng=%b D_pop=%h expected 1 01000000", pndng, D_pop);
    end
    tick(1, 32'h01000001, 0, 0, 0, 0);
    tick(1, 32'h01000002, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (D_pop !== 32'h01000000 + 32'(i) || act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL tx_order_%0d: got %h expected %h", i, D_pop, 32'h01000000 + 32'(i));
      end
      tick(0, 0, 1, 0, 0, 0);
    end
    checks++;
    if (pndng !== 1'b0 || D_pop !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL tx_drained: got pndng=%b D_pop=%h err=%b expected 0 0 0", pndng, D_pop, err);
    end
  endtask

  task automatic test_tx_full();
    logic [31:0] last;
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick(1, $urandom, 0, 0, 0, 0);
    checks++;
    if (tx_full !== 1'b1 || act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL tx_full_set: got %h expected %h", act_vec, exp_vec());
    end
    tick(1, 32'hDEAD0000, 0, 0, 0, 0);
    checks++;
    if (tx_m.size() != DEPTH || act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL tx_full_discard: got %h expected %h", act_vec, exp_vec());
    end
    last = 32'hBEEF0001;
    tick(1, last, 1, 0, 0, 0);
    checks++;
    if (tx_full !== 1'b1 || act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL tx_full_wr_pop: got %h expected %h", act_vec, exp_vec());
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        checks++;
        if (D_pop !== last) begin
          errors++;
          $display("FAIL tx_full_last_word: got %h expected %h", D_pop, last);
        end
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL tx_full_drain_%0d: got %h expected %h", i, act_vec, exp_vec());
      end
      tick(0, 0, 1, 0, 0, 0);
    end
    checks++;
    if (pndng !== 1'b0 || tx_full !== 1'b0 || D_pop !== 32'h0) begin
      errors++;
      $display("FAIL tx_full_empty: got pndng=%b full=%b D_pop=%h expected 0 0 0", pndng, tx_full, D_pop);
    end
  endtask

  task automatic test_rx_filter();
    do_reset();
    tick(0, 0, 0, 1, 32'h01000007, 0);
    checks++;
    if (rx_pndng !== 1'b1 || rx_data !== 32'h01000007) begin
      errors++;
      $display("FAIL rx_direct: got pndng=%b data=%h expected 1 01000007", rx_pndng, rx_data);
    end
    tick(0, 0, 0, 1, 32'h02000008, 0);
    checks++;
    if (misroute_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rx_misroute: got %0d expected 1", misroute_cnt);
    end
    tick(0, 0, 0, 1, 32'hFF000009, 0);
    tick(0, 0, 0, 1, 32'hFF01000A, 0);
    checks++;
    if (misroute_cnt !== 16'd1 || drop_cnt !== 16'd0 || rx_m.size() != 2 || act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL rx_echo: got %h expected %h", act_vec, exp_vec());
    end
    tick(0, 0, 0, 0, 0, 1);
    checks++;
    if (rx_data !== 32'hFF000009) begin
      errors++;
      $display("FAIL rx_broadcast: got %h expected ff000009", rx_data);
    end
    tick(0, 0, 0, 0, 0, 1);
    checks++;
    if (rx_pndng !== 1'b0 || rx_data !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rx_filter_empty: got pndng=%b data=%h err=%b expected 0 0 0", rx_pndng, rx_data, err);
    end
  endtask

  task automatic test_rx_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 1, {MY_ID, 8'h20, 16'(i)}, 0);
    checks++;
    if (drop_cnt !== 16'd4 || rx_data !== {MY_ID, 8'h20, 16'h0}) begin
      errors++;
      $display("FAIL rx_overflow: got drop=%0d head=%h expected 4 %h", drop_cnt, rx_data, {MY_ID, 8'h20, 16'h0});
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rx_data !== {MY_ID, 8'h20, 16'(i)} || act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rx_overflow_drain_%0d: got %h expected %h", i, rx_data, {MY_ID, 8'h20, 16'(i)});
      end
      tick(0, 0, 0, 0, 0, 1);
    end
    checks++;
    if (rx_pndng !== 1'b0 || drop_cnt !== 16'd4) begin
      errors++;
      $display("FAIL rx_overflow_end: got pndng=%b drop=%0d expected 0 4", rx_pndng, drop_cnt);
    end
  endtask

  task automatic test_errors();
    do_reset();
    tick(0, 0, 1, 0, 0, 0);
    checks++;
    if (err !== 1'b1 || pndng !== 1'b0) begin
      errors++;
      $display("FAIL err_tx_pop: got err=%b pndng=%b expected 1 0", err, pndng);
    end
    tick(1, 32'h01001234, 0, 0, 0, 0);
    checks++;
    if (D_pop !== 32'h01001234 || act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL err_ptr_hold: got %h expected 01001234", D_pop);
    end
    tick(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (err !== 1'b1 || pndng !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky: got err=%b pndng=%b expected 1 0", err, pndng);
    end
    do_reset();
    tick(1, 32'h01005555, 0, 0, 0, 1);
    checks++;
    if (err !== 1'b1 || D_pop !== 32'h01005555 || rx_pndng !== 1'b0) begin
      errors++;
      $display("FAIL err_rx_pop: got err=%b D_pop=%h rx_pndng=%b expected 1 01005555 0", err, D_pop, rx_pndng);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, $urandom, 0, (i < 3), {MY_ID, 24'(i)}, 0);
    tick(0, 0, 0, 1, 32'h05000000, 0);
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL mid_reset_prefill: got %h expected %h", act_vec, exp_vec());
    end
    do_reset();
    checks++;
    if (act_vec !== 100'h0) begin
      errors++;
      $display("FAIL mid_reset_clear: got %h expected %h", act_vec, 100'h0);
    end
    w = 32'h0100CAFE;
    tick(1, w, 0, 0, 0, 0);
    checks++;
    if (D_pop !== w || pndng !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_fresh: got %h expected %h", D_pop, w);
    end
    for (int i = 0; i < 40; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, rand_pkt(), $urandom_range(0, 2) == 0);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL mid_reset_mix_%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    int wr_bias, pop_bias;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      wr_bias  = (i % 100 < 50) ? 4 : 1;
      pop_bias = (i % 100 < 50) ? 1 : 4;
      tick($urandom_range(0, 4) < wr_bias, $urandom, $urandom_range(0, 4) < pop_bias,
           $urandom_range(0, 4) < wr_bias, rand_pkt(), $urandom_range(0, 4) < pop_bias);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tx_order();
    test_tx_full();
    test_rx_filter();
    test_rx_overflow();
    test_errors();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
